balance_arbiter: RTL and testbench

//  Owns the single account-balance register shared by two ATM front-ends (A, B).

---
 rtl/balance_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_balance_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/balance_arbiter.sv
// balance_arbiter: owns the single account-balance register shared by two ATM
// front-ends (A and B). Strobed deposit/withdrawal requests are captured per
// requester, arbitrated round-robin and applied one at a time. Each accepted
// request produces exactly one response pulse (ok or insufficient funds).
//
// Ports:
//   clk                       clock, rising edge
//   rst                       synchronous reset, active-low
//   stb_a / tipo_a / monto_a  requester A: strobe, 0=deposit 1=withdrawal, amount
//   stb_b / tipo_b / monto_b  requester B: same as A
//   ok_a / insuf_a            A response pulses
//   ok_b / insuf_b            B response pulses
//   balance                   current balance, registered
//   busy                      high while an operation is executing
module balance_arbiter #(
    parameter int unsigned           BALANCE_W    = 64,
    parameter logic [BALANCE_W-1:0]  BALANCE_INIT = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stb_a,
    input  logic                 tipo_a,
    input  logic [31:0]          monto_a,
    input  logic                 stb_b,
    input  logic                 tipo_b,
    input  logic [31:0]          monto_b,
    output logic                 ok_a,
    output logic                 insuf_a,
    output logic                 ok_b,
    output logic                 insuf_b,
    output logic [BALANCE_W-1:0] balance,
    output logic                 busy
);

    localparam int unsigned MONTO_W = 32;
    localparam int unsigned SUM_W   = BALANCE_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t               state, state_next;

    // Per-requester capture registers
    logic                 pend_a, pend_a_next;
    logic                 pend_b, pend_b_next;
    logic                 req_tipo_a, req_tipo_a_next;
    logic                 req_tipo_b, req_tipo_b_next;
    logic [MONTO_W-1:0]   req_monto_a, req_monto_a_next;
    logic [MONTO_W-1:0]   req_monto_b, req_monto_b_next;

    // prio: 0 = A wins a tie, 1 = B wins a tie
    logic                 prio, prio_next;

    // Operation being executed
    logic                 op_tipo, op_tipo_next;
    logic [MONTO_W-1:0]   op_monto, op_monto_next;
    logic                 op_who, op_who_next;

    logic [BALANCE_W-1:0] balance_next;
    logic                 ok_a_next, insuf_a_next, ok_b_next, insuf_b_next;
    logic                 busy_next;

    // Arithmetic helpers
    logic                 grant_b;
    logic [BALANCE_W-1:0] monto_ext;
    logic [SUM_W-1:0]     sum;
    logic                 funds_ok;

    // Next-state, capture, arbitration and execution
    always_comb begin
        state_next       = state;
        pend_a_next      = pend_a;
        pend_b_next      = pend_b;
        req_tipo_a_next  = req_tipo_a;
        req_tipo_b_next  = req_tipo_b;
        req_monto_a_next = req_monto_a;
        req_monto_b_next = req_monto_b;
        prio_next        = prio;
        op_tipo_next     = op_tipo;
        op_monto_next    = op_monto;
        op_who_next      = op_who;
        balance_next     = balance;
        ok_a_next        = 1'b0;
        insuf_a_next     = 1'b0;
        ok_b_next        = 1'b0;
        insuf_b_next     = 1'b0;

        monto_ext = BALANCE_W'(op_monto);
        sum       = SUM_W'(balance) + SUM_W'(op_monto);
        funds_ok  = (monto_ext <= balance);
        grant_b   = pend_b && (!pend_a || prio);

        // A strobe is only taken when no request from that side is pending
        if (stb_a && !pend_a) begin
            pend_a_next      = 1'b1;
            req_tipo_a_next  = tipo_a;
            req_monto_a_next = monto_a;
        end
        if (stb_b && !pend_b) begin
            pend_b_next      = 1'b1;
            req_tipo_b_next  = tipo_b;
            req_monto_b_next = monto_b;
        end

        case (state)
            IDLE: begin
                if (pend_a || pend_b) begin
                    state_next  = EXEC;
                    op_who_next = grant_b;
                    prio_next   = ~grant_b;
                    if (grant_b) begin
                        op_tipo_next  = req_tipo_b;
                        op_monto_next = req_monto_b;
                        pend_b_next   = 1'b0;
                    end else begin
                        op_tipo_next  = req_tipo_a;
                        op_monto_next = req_monto_a;
                        pend_a_next   = 1'b0;
                    end
                end
            end
            EXEC: begin
                state_next = IDLE;
                if (!op_tipo) begin
                    // Deposit saturates at all-ones
                    balance_next = sum[BALANCE_W] ? '1 : sum[BALANCE_W-1:0];
                    ok_a_next    = !op_who;
                    ok_b_next    = op_who;
                end else if (funds_ok) begin
                    balance_next = balance - monto_ext;
                    ok_a_next    = !op_who;
                    ok_b_next    = op_who;
                end else begin
                    insuf_a_next = !op_who;
                    insuf_b_next = op_who;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == EXEC);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            pend_a      <= 1'b0;
            pend_b      <= 1'b0;
            req_tipo_a  <= 1'b0;
            req_tipo_b  <= 1'b0;
            req_monto_a <= '0;
            req_monto_b <= '0;
            prio        <= 1'b0;
            op_tipo     <= 1'b0;
            op_monto    <= '0;
            op_who      <= 1'b0;
            balance     <= BALANCE_INIT;
            ok_a        <= 1'b0;
            insuf_a     <= 1'b0;
            ok_b        <= 1'b0;
            insuf_b     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            pend_a      <= pend_a_next;
            pend_b      <= pend_b_next;
            req_tipo_a  <= req_tipo_a_next;
            req_tipo_b  <= req_tipo_b_next;
            req_monto_a <= req_monto_a_next;
            req_monto_b <= req_monto_b_next;
            prio        <= prio_next;
            op_tipo     <= op_tipo_next;
            op_monto    <= op_monto_next;
            op_who      <= op_who_next;
            balance     <= balance_next;
            ok_a        <= ok_a_next;
            insuf_a     <= insuf_a_next;
            ok_b        <= ok_b_next;
            insuf_b     <= insuf_b_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_balance_arbiter.sv
// tb_balance_arbiter: table-driven cycle vectors for a 64-bit instance, plus a
// hand-written saturation/exact-withdrawal sequence on a 32-bit instance.
module tb_balance_arbiter;

    localparam logic       DEP = 1'b0;
    localparam logic       WD  = 1'b1;
    localparam logic [3:0] R0  = 4'b0000;
    localparam logic [3:0] OKA = 4'b1000;
    localparam logic [3:0] INA = 4'b0100;
    localparam logic [3:0] OKB = 4'b0010;
    localparam logic [3:0] INB = 4'b0001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        stb_a = 1'b0, tipo_a = 1'b0, stb_b = 1'b0, tipo_b = 1'b0;
    logic [31:0] monto_a = '0, monto_b = '0;
    logic        ok_a, insuf_a, ok_b, insuf_b, busy;
    logic [63:0] balance;

    logic        s2_stb_a = 1'b0, s2_tipo_a = 1'b0, s2_stb_b = 1'b0, s2_tipo_b = 1'b0;
    logic [31:0] s2_monto_a = '0, s2_monto_b = '0;
    logic        s2_ok_a, s2_insuf_a, s2_ok_b, s2_insuf_b, s2_busy;
    logic [31:0] s2_balance;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    balance_arbiter #(.BALANCE_W(64), .BALANCE_INIT(64'd0)) dut64 (
        .clk(clk), .rst(rst),
        .stb_a(stb_a), .tipo_a(tipo_a), .monto_a(monto_a),
        .stb_b(stb_b), .tipo_b(tipo_b), .monto_b(monto_b),
        .ok_a(ok_a), .insuf_a(insuf_a), .ok_b(ok_b), .insuf_b(insuf_b),
        .balance(balance), .busy(busy)
    );

    balance_arbiter #(.BALANCE_W(32), .BALANCE_INIT(32'hFFFF_FFF0)) dut32 (
        .clk(clk), .rst(rst),
        .stb_a(s2_stb_a), .tipo_a(s2_tipo_a), .monto_a(s2_monto_a),
        .stb_b(s2_stb_b), .tipo_b(s2_tipo_b), .monto_b(s2_monto_b),
        .ok_a(s2_ok_a), .insuf_a(s2_insuf_a), .ok_b(s2_ok_b), .insuf_b(s2_insuf_b),
        .balance(s2_balance), .busy(s2_busy)
    );

    typedef struct {
        logic        r;
        logic        sa;
        logic        ta;
        logic [31:0] ma;
        logic        sb;
        logic        tpb;
        logic [31:0] mb;
        logic [3:0]  resp;
        logic [63:0] bal;
        logic        bsy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic sa, logic ta, logic [31:0] ma,
                                logic sb, logic tpb, logic [31:0] mb,
                                logic [3:0] resp, logic [63:0] bal, logic bsy);
        vec_t v;
        v.r = r; v.sa = sa; v.ta = ta; v.ma = ma;
        v.sb = sb; v.tpb = tpb; v.mb = mb;
        v.resp = resp; v.bal = bal; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe one request into dut32 and check its single response
    task automatic run32(input string name, input logic side_b, input logic tipo,
                         input logic [31:0] monto, input logic [3:0] exp_resp,
                         input logic [31:0] exp_bal);
        int lat;
        logic [3:0] resp;
        @(negedge clk);
        if (side_b) begin
            s2_stb_b = 1'b1; s2_tipo_b = tipo; s2_monto_b = monto;
        end else begin
            s2_stb_a = 1'b1; s2_tipo_a = tipo; s2_monto_a = monto;
        end
        @(posedge clk);
        #1;
        s2_stb_a = 1'b0;
        s2_stb_b = 1'b0;
        lat  = 0;
        resp = R0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            resp = {s2_ok_a, s2_insuf_a, s2_ok_b, s2_insuf_b};
            if (resp != R0) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no response expected %0h", name, exp_resp);
        end else begin
            chk({name, " latency"}, 64'(lat), 64'd2);
            chk({name, " resp"}, 64'(resp), 64'(exp_resp));
            chk({name, " balance"}, 64'(s2_balance), 64'(exp_bal));
        end
    endtask

    initial begin
        // Test 1/2: single-requester ops and insufficient funds
        vq.push_back(mk(0, 0, DEP, 0,     0, DEP, 0,     R0,  0, 0));
        vq.push_back(mk(1, 1, DEP, 10000, 0, DEP, 0,     R0,  0, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  0, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKA, 10000, 0));
        vq.push_back(mk(1, 1, WD,  10000, 0, DEP, 0,     R0,  10000, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  10000, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKA, 0, 0));
        vq.push_back(mk(1, 0, DEP, 0,     1, WD,  10000, R0,  0, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  0, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     INB, 0, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  0, 0));
        // Test 3: simultaneous strobes, round-robin
        vq.push_back(mk(0, 0, DEP, 0,     0, DEP, 0,     R0,  0, 0));
        vq.push_back(mk(1, 1, DEP, 3000,  1, WD,  1000,  R0,  0, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  0, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKA, 3000, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  3000, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKB, 2000, 0));
        vq.push_back(mk(1, 1, DEP, 3000,  1, WD,  1000,  R0,  2000, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  2000, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKA, 5000, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  5000, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKB, 4000, 0));
        // A alone, then a tie: B now has priority
        vq.push_back(mk(1, 1, DEP, 1,     0, DEP, 0,     R0,  4000, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  4000, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKA, 4001, 0));
        vq.push_back(mk(1, 1, DEP, 10,    1, DEP, 20,    R0,  4001, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  4001, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKB, 4021, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  4021, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKA, 4031, 0));
        // Test 4: second strobe while pending is dropped
        vq.push_back(mk(1, 1, DEP, 5,     0, DEP, 0,     R0,  4031, 0));
        vq.push_back(mk(1, 1, DEP, 7,     0, DEP, 0,     R0,  4031, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKA, 4036, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  4036, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  4036, 0));
        // Strobe during own EXEC is captured
        vq.push_back(mk(1, 1, DEP, 100,   0, DEP, 0,     R0,  4036, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  4036, 1));
        vq.push_back(mk(1, 1, DEP, 200,   0, DEP, 0,     OKA, 4136, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  4136, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKA, 4336, 0));
        // Other side's strobe during EXEC waits; then insufficient funds
        vq.push_back(mk(1, 1, WD,  336,   0, DEP, 0,     R0,  4336, 0));
        vq.push_back(mk(1, 0, DEP, 0,     1, WD,  5000,  R0,  4336, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKA, 4000, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  4000, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     INB, 4000, 0));
        // Zero-amount withdrawal
        vq.push_back(mk(1, 0, DEP, 0,     1, WD,  0,     R0,  4000, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  4000, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKB, 4000, 0));
        // Test 6: reset while busy aborts the operation
        vq.push_back(mk(1, 1, DEP, 50,    0, DEP, 0,     R0,  4000, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  4000, 1));
        vq.push_back(mk(0, 0, DEP, 0,     0, DEP, 0,     R0,  0, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  0, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  0, 0));
        vq.push_back(mk(1, 0, DEP, 0,     1, DEP, 9,     R0,  0, 0));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     R0,  0, 1));
        vq.push_back(mk(1, 0, DEP, 0,     0, DEP, 0,     OKB, 9, 0));

        @(negedge clk);
        foreach (vq[i]) begin
            rst = vq[i].r;
            stb_a = vq[i].sa; tipo_a = vq[i].ta;  monto_a = vq[i].ma;
            stb_b = vq[i].sb; tipo_b = vq[i].tpb; monto_b = vq[i].mb;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d resp", i), 64'({ok_a, insuf_a, ok_b, insuf_b}), 64'(vq[i].resp));
            chk($sformatf("v%0d balance", i), balance, vq[i].bal);
            chk($sformatf("v%0d busy", i), 64'(busy), 64'(vq[i].bsy));
            @(negedge clk);
        end
        stb_a = 1'b0;
        stb_b = 1'b0;

        // Test 5: 32-bit saturation and exact withdrawal to zero
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("w32 reset balance", 64'(s2_balance), 64'h0000_0000_FFFF_FFF0);
        @(negedge clk);
        rst = 1'b1;
        run32("w32 sat dep", 1'b0, DEP, 32'h20,        OKA, 32'hFFFF_FFFF);
        run32("w32 wd all",  1'b1, WD,  32'hFFFF_FFFF, OKB, 32'h0);
        run32("w32 wd empty", 1'b0, WD, 32'h1,         INA, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
